// File: rtl/msi_irq_arbiter.sv
// Multi-channel MSI interrupt source: edge-detects N IRQ lines, round-robin
// arbitrates pending channels onto the cfg_interrupt handshake. Optional MSI_RATE_LIMIT_EN adds a GAP state.
module msi_irq_arbiter #(
    parameter int NUM_CHANNELS = 8,
    parameter int MIN_GAP      = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CHANNELS-1:0] irq_in,
    input  logic [NUM_CHANNELS-1:0] irq_mask,
    input  logic                    msi_enable,
    input  logic [2:0]              msi_vector_width,
    output logic                    intx_msi_request,
    input  logic                    intx_msi_grant,
    output logic [4:0]              msi_vector_num,
    output logic [NUM_CHANNELS-1:0] pending,
    output logic                    sent_pulse,
    output logic [4:0]              sent_channel
);
    localparam int CW = 5;

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 32 || MIN_GAP < 1 || MIN_GAP > 65535) begin : g_bad_param
        $error("msi_irq_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1
`ifdef MSI_RATE_LIMIT_EN
        , GAP = 2'd2
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_CHANNELS-1:0] irq_q;
    logic [NUM_CHANNELS-1:0] pending_q, pending_d;
    logic [CW-1:0]           ptr_q, ptr_d;
    logic [CW-1:0]           ch_q, ch_d;
    logic [CW-1:0]           vec_q, vec_d;
    logic                    req_q, req_d;
    logic                    sent_pulse_q, sent_pulse_d;
    logic [CW-1:0]           sent_ch_q, sent_ch_d;
`ifdef MSI_RATE_LIMIT_EN
    logic [15:0]             gap_cnt_q, gap_cnt_d;
`endif

    logic [NUM_CHANNELS-1:0] evt;
    logic [NUM_CHANNELS-1:0] eligible;
    logic [NUM_CHANNELS-1:0] clr;
    logic                    grant_fire;
    logic                    win_found;
    logic [CW-1:0]           win_ch;
    logic [CW-1:0]           win_vec;
    logic [2:0]              alloc_log;
    logic [5:0]              alloc;
    int                      idx;

    assign evt      = irq_in & ~irq_q;
    assign eligible = pending_q & ~irq_mask & {NUM_CHANNELS{msi_enable}};

    // Round-robin: first eligible channel at or after the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_ch    = CW'(idx);
            end
        end
    end

    // Channels beyond the host allocation fold onto the last allocated vector.
    always_comb begin
        alloc_log = (msi_vector_width > 3'd5) ? 3'd5 : msi_vector_width;
        alloc     = 6'd1 << alloc_log;
        if ({1'b0, win_ch} < alloc) win_vec = win_ch;
        else                        win_vec = CW'(alloc - 6'd1);
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        ch_d         = ch_q;
        vec_d        = vec_q;
        ptr_d        = ptr_q;
        sent_pulse_d = 1'b0;
        sent_ch_d    = sent_ch_q;
        grant_fire   = 1'b0;
`ifdef MSI_RATE_LIMIT_EN
        gap_cnt_d    = gap_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    ch_d    = win_ch;
                    vec_d   = win_vec;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (intx_msi_grant) begin
                    req_d        = 1'b0;
                    grant_fire   = 1'b1;
                    sent_pulse_d = 1'b1;
                    sent_ch_d    = ch_q;
                    ptr_d        = (ch_q == CW'(NUM_CHANNELS - 1)) ? '0 : ch_q + 1'b1;
`ifdef MSI_RATE_LIMIT_EN
                    gap_cnt_d    = 16'(MIN_GAP - 1);
                    state_d      = GAP;
`else
                    state_d      = IDLE;
`endif
                end else if (!msi_enable) begin
                    // Host withdrew MSI: abandon the message, keep it pending.
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
`ifdef MSI_RATE_LIMIT_EN
            GAP: begin
                if (gap_cnt_q == 16'd0) state_d = IDLE;
                else                    gap_cnt_d = gap_cnt_q - 16'd1;
            end
`endif
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // A new event on the granted channel wins over the clear.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) clr[i] = grant_fire && (ch_q == CW'(i));
        pending_d = (pending_q & ~clr) | evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            irq_q        <= '0;
            pending_q    <= '0;
            ptr_q        <= '0;
            ch_q         <= '0;
            vec_q        <= '0;
            req_q        <= 1'b0;
            sent_pulse_q <= 1'b0;
            sent_ch_q    <= '0;
`ifdef MSI_RATE_LIMIT_EN
            gap_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_in;
            pending_q    <= pending_d;
            ptr_q        <= ptr_d;
            ch_q         <= ch_d;
            vec_q        <= vec_d;
            req_q        <= req_d;
            sent_pulse_q <= sent_pulse_d;
            sent_ch_q    <= sent_ch_d;
`ifdef MSI_RATE_LIMIT_EN
            gap_cnt_q    <= gap_cnt_d;
`endif
        end
    end

    assign intx_msi_request = req_q;
    assign msi_vector_num   = vec_q;
    assign pending          = pending_q;
    assign sent_pulse       = sent_pulse_q;
    assign sent_channel     = sent_ch_q;

endmodule
